// File: rtl/omsp_gfx_vram_arbiter.sv
// Video-RAM arbiter: one single-port RAM shared by refresh, GPU and CPU requesters.
// Define OMSP_GFX_VRAM_ARB_WATCHDOG_EN to add the refresh-starvation watchdog.
`ifndef VRAM_MSB
`define VRAM_MSB 16
`endif

module omsp_gfx_vram_arbiter #(
  parameter int WDG_LIMIT = 4
) (
  input  logic                mclk,
  input  logic                puc_rst_n,
  input  logic [`VRAM_MSB:0]  refr_addr_i,
  input  logic                refr_cen_i,
  output logic                refr_ack_o,
  output logic                refr_dout_rdy_nxt_o,
  input  logic [`VRAM_MSB:0]  gpu_addr_i,
  input  logic                gpu_cen_i,
  input  logic [1:0]          gpu_wen_i,
  input  logic [15:0]         gpu_din_i,
  output logic                gpu_ack_o,
  output logic                gpu_dout_rdy_nxt_o,
  input  logic [`VRAM_MSB:0]  cpu_addr_i,
  input  logic                cpu_cen_i,
  input  logic [1:0]          cpu_wen_i,
  input  logic [15:0]         cpu_din_i,
  output logic                cpu_ack_o,
  output logic                cpu_dout_rdy_nxt_o,
  output logic [`VRAM_MSB:0]  vid_ram_addr_o,
  output logic                vid_ram_cen_o,
  output logic [1:0]          vid_ram_wen_o,
  output logic [15:0]         vid_ram_din_o,
  input  logic [15:0]         vid_ram_dout_i,
  output logic [15:0]         vid_ram_dout_o
);

  logic               refr_req, gpu_req, cpu_req;
  logic               refr_gnt, gpu_gnt, cpu_gnt;
  logic               rr_last;
  logic               wdg_exp;
  logic [`VRAM_MSB:0] addr_hold;
  logic [15:0]        din_hold;

  assign refr_req = ~refr_cen_i;
  assign gpu_req  = ~gpu_cen_i;
  assign cpu_req  = ~cpu_cen_i;

`ifdef OMSP_GFX_VRAM_ARB_WATCHDOG_EN
  logic [3:0] wdg_cnt;

  assign wdg_exp = refr_req & (wdg_cnt == 4'(WDG_LIMIT));

  always_ff @(posedge mclk) begin
    if (!puc_rst_n)
      wdg_cnt <= '0;
    else if (refr_gnt || !refr_req)
      wdg_cnt <= '0;
    else if (wdg_cnt != 4'(WDG_LIMIT))
      wdg_cnt <= wdg_cnt + 4'd1;
  end
`else
  logic [3:0] unused_wdg_limit;

  assign unused_wdg_limit = 4'(WDG_LIMIT);
  assign wdg_exp          = 1'b0;
`endif

  // Grant: expired watchdog, then CPU, then GPU/refresh round-robin.
  always_comb begin
    refr_gnt = 1'b0;
    gpu_gnt  = 1'b0;
    cpu_gnt  = 1'b0;
    if (puc_rst_n) begin
      if (wdg_exp) begin
        refr_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (gpu_req && refr_req) begin
        gpu_gnt  = ~rr_last;
        refr_gnt = rr_last;
      end else begin
        gpu_gnt  = gpu_req;
        refr_gnt = refr_req;
      end
    end
  end

  // Refresh only reads, so it keeps the held write data on the RAM bus.
  always_comb begin
    vid_ram_cen_o  = 1'b1;
    vid_ram_wen_o  = 2'b11;
    vid_ram_addr_o = addr_hold;
    vid_ram_din_o  = din_hold;
    if (cpu_gnt) begin
      vid_ram_cen_o  = 1'b0;
      vid_ram_wen_o  = cpu_wen_i;
      vid_ram_addr_o = cpu_addr_i;
      vid_ram_din_o  = cpu_din_i;
    end else if (gpu_gnt) begin
      vid_ram_cen_o  = 1'b0;
      vid_ram_wen_o  = gpu_wen_i;
      vid_ram_addr_o = gpu_addr_i;
      vid_ram_din_o  = gpu_din_i;
    end else if (refr_gnt) begin
      vid_ram_cen_o  = 1'b0;
      vid_ram_addr_o = refr_addr_i;
    end
  end

  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      rr_last   <= 1'b1;
      addr_hold <= '0;
      din_hold  <= '0;
    end else begin
      addr_hold <= vid_ram_addr_o;
      din_hold  <= vid_ram_din_o;
      if (refr_gnt)
        rr_last <= 1'b0;
      else if (gpu_gnt)
        rr_last <= 1'b1;
    end
  end

  assign refr_ack_o          = refr_gnt;
  assign gpu_ack_o           = gpu_gnt;
  assign cpu_ack_o           = cpu_gnt;
  assign refr_dout_rdy_nxt_o = refr_gnt;
  assign gpu_dout_rdy_nxt_o  = gpu_gnt & (gpu_wen_i == 2'b11);
  assign cpu_dout_rdy_nxt_o  = cpu_gnt & (cpu_wen_i == 2'b11);
  assign vid_ram_dout_o      = vid_ram_dout_i;

endmodule

// File: tb/tb_omsp_gfx_vram_arbiter.sv
// Bench for omsp_gfx_vram_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of the arbitration rules.
`ifndef VRAM_MSB
`define VRAM_MSB 16
`endif

module tb_omsp_gfx_vram_arbiter;
  localparam int AW        = `VRAM_MSB + 1;
  localparam int WDG_LIMIT = 4;

  logic          mclk;
  logic          puc_rst_n;
  logic [AW-1:0] refr_addr_i, gpu_addr_i, cpu_addr_i, vid_ram_addr_o;
  logic          refr_cen_i, gpu_cen_i, cpu_cen_i, vid_ram_cen_o;
  logic [1:0]    gpu_wen_i, cpu_wen_i, vid_ram_wen_o;
  logic [15:0]   gpu_din_i, cpu_din_i, vid_ram_din_o, vid_ram_dout_i, vid_ram_dout_o;
  logic          refr_ack_o, gpu_ack_o, cpu_ack_o;
  logic          refr_dout_rdy_nxt_o, gpu_dout_rdy_nxt_o, cpu_dout_rdy_nxt_o;

  omsp_gfx_vram_arbiter #(.WDG_LIMIT(WDG_LIMIT)) dut (
    .mclk(mclk), .puc_rst_n(puc_rst_n),
    .refr_addr_i(refr_addr_i), .refr_cen_i(refr_cen_i), .refr_ack_o(refr_ack_o),
    .refr_dout_rdy_nxt_o(refr_dout_rdy_nxt_o),
    .gpu_addr_i(gpu_addr_i), .gpu_cen_i(gpu_cen_i), .gpu_wen_i(gpu_wen_i), .gpu_din_i(gpu_din_i),
    .gpu_ack_o(gpu_ack_o), .gpu_dout_rdy_nxt_o(gpu_dout_rdy_nxt_o),
    .cpu_addr_i(cpu_addr_i), .cpu_cen_i(cpu_cen_i), .cpu_wen_i(cpu_wen_i), .cpu_din_i(cpu_din_i),
    .cpu_ack_o(cpu_ack_o), .cpu_dout_rdy_nxt_o(cpu_dout_rdy_nxt_o),
    .vid_ram_addr_o(vid_ram_addr_o), .vid_ram_cen_o(vid_ram_cen_o), .vid_ram_wen_o(vid_ram_wen_o),
    .vid_ram_din_o(vid_ram_din_o), .vid_ram_dout_i(vid_ram_dout_i), .vid_ram_dout_o(vid_ram_dout_o)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  function automatic logic [15:0] init_word(int i);
    return 16'(i * 40503 + 12345);
  endfunction

  // Behavioural single-port RAM with one-cycle read latency.
  logic [15:0] ram [0:255];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    forever begin
      @(posedge mclk);
      if (!vid_ram_cen_o) begin
        if (vid_ram_wen_o == 2'b11) vid_ram_dout_i <= ram[vid_ram_addr_o[7:0]];
        else begin
          if (!vid_ram_wen_o[0]) ram[vid_ram_addr_o[7:0]][7:0]  <= vid_ram_din_o[7:0];
          if (!vid_ram_wen_o[1]) ram[vid_ram_addr_o[7:0]][15:8] <= vid_ram_din_o[15:8];
        end
      end
    end
  end

  // Reference model state, in terms of requesters rather than RTL registers.
  typedef enum int {W_NONE, W_REFR, W_GPU, W_CPU} who_t;
  bit            refr_turn;
  int            refr_denied;
  logic [AW-1:0] last_addr;
  logic [15:0]   last_din;
  logic [15:0]   ref_mem [0:255];
  bit            rd_pending;
  logic [15:0]   rd_data;
  who_t          last_win;
  int            checks, errors;

  function automatic who_t exp_winner();
    if (puc_rst_n !== 1'b1) return W_NONE;
`ifdef OMSP_GFX_VRAM_ARB_WATCHDOG_EN
    if (!refr_cen_i && refr_denied >= WDG_LIMIT) return W_REFR;
`endif
    if (!cpu_cen_i) return W_CPU;
    if (!gpu_cen_i && !refr_cen_i) return refr_turn ? W_REFR : W_GPU;
    if (!gpu_cen_i) return W_GPU;
    if (!refr_cen_i) return W_REFR;
    return W_NONE;
  endfunction

  function automatic logic [AW-1:0] exp_addr(who_t w);
    case (w)
      W_REFR:  return refr_addr_i;
      W_GPU:   return gpu_addr_i;
      W_CPU:   return cpu_addr_i;
      default: return last_addr;
    endcase
  endfunction

  function automatic logic [1:0] exp_wen(who_t w);
    case (w)
      W_GPU:   return gpu_wen_i;
      W_CPU:   return cpu_wen_i;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [15:0] exp_din(who_t w);
    case (w)
      W_GPU:   return gpu_din_i;
      W_CPU:   return cpu_din_i;
      default: return last_din;
    endcase
  endfunction

  // Advance one clock: update the model at the edge, return at the falling edge.
  task automatic step();
    who_t          w;
    logic [AW-1:0] a;
    logic [1:0]    we;
    logic [15:0]   d;
    @(posedge mclk);
    w  = exp_winner();
    a  = exp_addr(w);
    we = exp_wen(w);
    d  = exp_din(w);
    rd_pending = 1'b0;
    if (puc_rst_n !== 1'b1) begin
      refr_turn   = 1'b1;
      refr_denied = 0;
      last_addr   = '0;
      last_din    = '0;
    end else begin
      if (w == W_REFR) begin
        refr_turn   = 1'b0;
        refr_denied = 0;
      end else begin
        if (w == W_GPU) refr_turn = 1'b0 == 1'b0;
        if (refr_cen_i) refr_denied = 0;
        else if (refr_denied < WDG_LIMIT) refr_denied++;
      end
      last_addr = a;
      last_din  = d;
      if (w != W_NONE) begin
        if (we == 2'b11) begin
          rd_pending = 1'b1;
          rd_data    = ref_mem[a[7:0]];
        end else begin
          if (!we[0]) ref_mem[a[7:0]][7:0]  = d[7:0];
          if (!we[1]) ref_mem[a[7:0]][15:8] = d[15:8];
        end
      end
    end
    last_win = w;
    @(negedge mclk);
  endtask

  task automatic idle_all();
    refr_cen_i = 1'b1;
    gpu_cen_i  = 1'b1;
    cpu_cen_i  = 1'b1;
    gpu_wen_i  = 2'b11;
    cpu_wen_i  = 2'b11;
  endtask

  task automatic do_reset();
    idle_all();
    puc_rst_n = 1'b0;
    step();
    step();
    puc_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    puc_rst_n = 1'b0;
    refr_cen_i = 1'b0; gpu_cen_i = 1'b0; cpu_cen_i = 1'b0;
    refr_addr_i = AW'(5); gpu_addr_i = AW'(6); cpu_addr_i = AW'(7);
    gpu_din_i = 16'h1111; cpu_din_i = 16'h2222;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({refr_ack_o, gpu_ack_o, cpu_ack_o} !== 3'b000) begin
        errors++; $display("FAIL reset_ack: got %b required 000", {refr_ack_o, gpu_ack_o, cpu_ack_o});
      end
      checks++;
      if ({refr_dout_rdy_nxt_o, gpu_dout_rdy_nxt_o, cpu_dout_rdy_nxt_o} !== 3'b000) begin
        errors++; $display("FAIL reset_rdy: got %b required 000",
                           {refr_dout_rdy_nxt_o, gpu_dout_rdy_nxt_o, cpu_dout_rdy_nxt_o});
      end
      checks++;
      if (vid_ram_cen_o !== 1'b1 || vid_ram_wen_o !== 2'b11) begin
        errors++; $display("FAIL reset_ram_ctl: got cen %b wen %b required 1 11", vid_ram_cen_o, vid_ram_wen_o);
      end
      if (c == 1) begin
        checks++;
        if (vid_ram_addr_o !== '0 || vid_ram_din_o !== 16'h0) begin
          errors++; $display("FAIL reset_addr_din: got %0h %0h required 0 0", vid_ram_addr_o, vid_ram_din_o);
        end
      end
      step();
    end
    puc_rst_n = 1'b1;
    idle_all();
  endtask

  task automatic test_refresh_only();
    idle_all();
    for (int i = 0; i < 8; i++) begin
      refr_cen_i  = 1'b0;
      refr_addr_i = AW'(8'h10 + i);
      #1;
      checks++;
      if (refr_ack_o !== 1'b1 || refr_dout_rdy_nxt_o !== 1'b1) begin
        errors++; $display("FAIL refr_only_ack[%0d]: got ack %b rdy %b required 1 1", i, refr_ack_o, refr_dout_rdy_nxt_o);
      end
      checks++;
      if (vid_ram_addr_o !== AW'(8'h10 + i) || vid_ram_cen_o !== 1'b0 || vid_ram_wen_o !== 2'b11) begin
        errors++; $display("FAIL refr_only_ram[%0d]: got addr %0h cen %b wen %b required %0h 0 11",
                           i, vid_ram_addr_o, vid_ram_cen_o, vid_ram_wen_o, 8'h10 + i);
      end
      if (i > 0) begin
        checks++;
        if (vid_ram_dout_o !== init_word(8'h10 + i - 1)) begin
          errors++; $display("FAIL refr_only_data[%0d]: got %0h required %0h", i, vid_ram_dout_o, init_word(8'h10 + i - 1));
        end
      end
      step();
    end
    refr_cen_i = 1'b1;
    #1;
    checks++;
    if (vid_ram_dout_o !== init_word(8'h17)) begin
      errors++; $display("FAIL refr_only_last_data: got %0h required %0h", vid_ram_dout_o, init_word(8'h17));
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    gpu_cen_i = 1'b0; gpu_addr_i = AW'(8'h30); gpu_wen_i = 2'b00; gpu_din_i = 16'h1234;
    refr_cen_i = 1'b0; refr_addr_i = AW'(8'h31);
    for (int i = 0; i < 6; i++) begin
      bit r;
      r = (i % 2) == 0;
      #1;
      checks++;
      if (refr_ack_o !== r || gpu_ack_o !== !r) begin
        errors++; $display("FAIL rr_grant[%0d]: got refr %b gpu %b required %b %b", i, refr_ack_o, gpu_ack_o, r, !r);
      end
      checks++;
      if (vid_ram_wen_o !== (r ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL rr_wen[%0d]: got %b required %b", i, vid_ram_wen_o, r ? 2'b11 : 2'b00);
      end
      step();
    end
    idle_all();
  endtask

  task automatic test_gpu_write();
    idle_all();
    gpu_cen_i = 1'b0; gpu_addr_i = AW'(8'h20); gpu_wen_i = 2'b01; gpu_din_i = 16'hA5A5;
    #1;
    checks++;
    if (gpu_ack_o !== 1'b1 || gpu_dout_rdy_nxt_o !== 1'b0) begin
      errors++; $display("FAIL gpu_wr_ack: got ack %b rdy %b required 1 0", gpu_ack_o, gpu_dout_rdy_nxt_o);
    end
    checks++;
    if (vid_ram_wen_o !== 2'b01 || vid_ram_din_o !== 16'hA5A5 || vid_ram_addr_o !== AW'(8'h20)) begin
      errors++; $display("FAIL gpu_wr_ram: got wen %b din %0h addr %0h required 01 a5a5 20",
                         vid_ram_wen_o, vid_ram_din_o, vid_ram_addr_o);
    end
    step();
    idle_all();
    #1;
    checks++;
    if (vid_ram_cen_o !== 1'b1 || vid_ram_din_o !== 16'hA5A5 || vid_ram_addr_o !== AW'(8'h20)) begin
      errors++; $display("FAIL gpu_wr_hold: got cen %b din %0h addr %0h required 1 a5a5 20",
                         vid_ram_cen_o, vid_ram_din_o, vid_ram_addr_o);
    end
  endtask

  task automatic test_cpu_refresh();
    do_reset();
    cpu_cen_i = 1'b0; cpu_addr_i = AW'(8'h40); cpu_wen_i = 2'b11;
    refr_cen_i = 1'b0; refr_addr_i = AW'(8'h41);
    for (int i = 0; i < 10; i++) begin
      bit r;
`ifdef OMSP_GFX_VRAM_ARB_WATCHDOG_EN
      r = (i % (WDG_LIMIT + 1)) == WDG_LIMIT;
`else
      r = 1'b0;
`endif
      #1;
      checks++;
      if (refr_ack_o !== r || cpu_ack_o !== !r) begin
        errors++; $display("FAIL cpu_refr[%0d]: got refr %b cpu %b required %b %b", i, refr_ack_o, cpu_ack_o, r, !r);
      end
      step();
    end
    idle_all();
  endtask

  task automatic test_all_three();
    do_reset();
    gpu_cen_i = 1'b0; gpu_addr_i = AW'(8'h50); gpu_wen_i = 2'b11;
    cpu_cen_i = 1'b0; cpu_addr_i = AW'(8'h51); cpu_wen_i = 2'b11;
    refr_cen_i = 1'b0; refr_addr_i = AW'(8'h52);
    #1;
    checks++;
    if ({cpu_ack_o, refr_ack_o, gpu_ack_o} !== 3'b100) begin
      errors++; $display("FAIL all3_first: got c/r/g %b required 100", {cpu_ack_o, refr_ack_o, gpu_ack_o});
    end
    step();
    cpu_cen_i = 1'b1;
    #1;
    checks++;
    if ({cpu_ack_o, refr_ack_o, gpu_ack_o} !== 3'b010) begin
      errors++; $display("FAIL all3_second: got c/r/g %b required 010", {cpu_ack_o, refr_ack_o, gpu_ack_o});
    end
    step();
    #1;
    checks++;
    if ({cpu_ack_o, refr_ack_o, gpu_ack_o} !== 3'b001) begin
      errors++; $display("FAIL all3_third: got c/r/g %b required 001", {cpu_ack_o, refr_ack_o, gpu_ack_o});
    end
    step();
    idle_all();
  endtask

  task automatic test_reset_mid_traffic();
    cpu_cen_i = 1'b0; cpu_addr_i = AW'(8'h60); cpu_wen_i = 2'b11;
    refr_cen_i = 1'b0; refr_addr_i = AW'(8'h61);
    for (int i = 0; i < 3; i++) step();
    gpu_cen_i = 1'b0; gpu_addr_i = AW'(8'h62); gpu_wen_i = 2'b11;
    puc_rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({cpu_ack_o, refr_ack_o, gpu_ack_o} !== 3'b000 || vid_ram_cen_o !== 1'b1) begin
        errors++; $display("FAIL mid_reset[%0d]: got acks %b cen %b required 000 1",
                           i, {cpu_ack_o, refr_ack_o, gpu_ack_o}, vid_ram_cen_o);
      end
      step();
    end
    puc_rst_n = 1'b1;
    for (int i = 0; i < WDG_LIMIT; i++) begin
      #1;
      checks++;
      if ({cpu_ack_o, refr_ack_o, gpu_ack_o} !== 3'b100) begin
        errors++; $display("FAIL post_reset_cpu[%0d]: got c/r/g %b required 100", i, {cpu_ack_o, refr_ack_o, gpu_ack_o});
      end
      step();
    end
`ifndef OMSP_GFX_VRAM_ARB_WATCHDOG_EN
    cpu_cen_i = 1'b1;
`endif
    #1;
    checks++;
    if ({cpu_ack_o, refr_ack_o, gpu_ack_o} !== 3'b010) begin
      errors++; $display("FAIL post_reset_first_nc: got c/r/g %b required 010", {cpu_ack_o, refr_ack_o, gpu_ack_o});
    end
    step();
    idle_all();
  endtask

  task automatic test_random();
    who_t w;
    idle_all();
    for (int cyc = 0; cyc < 600; cyc++) begin
      int cpu_pct;
      cpu_pct = (cyc < 300) ? 90 : 25;
      if (cpu_cen_i && $urandom_range(0, 99) < cpu_pct) begin
        cpu_cen_i = 1'b0; cpu_addr_i = AW'($urandom_range(0, 255));
        cpu_wen_i = 2'($urandom); cpu_din_i = 16'($urandom);
      end
      if (gpu_cen_i && $urandom_range(0, 1) == 0) begin
        gpu_cen_i = 1'b0; gpu_addr_i = AW'($urandom_range(0, 255));
        gpu_wen_i = 2'($urandom); gpu_din_i = 16'($urandom);
      end
      if (refr_cen_i && $urandom_range(0, 1) == 0) begin
        refr_cen_i = 1'b0; refr_addr_i = AW'($urandom_range(0, 255));
      end
      #1;
      w = exp_winner();
      checks++;
      if ({refr_ack_o, gpu_ack_o, cpu_ack_o} !== {w == W_REFR, w == W_GPU, w == W_CPU}) begin
        errors++; $display("FAIL rand_ack[%0d]: got r/g/c %b required %b", cyc,
                           {refr_ack_o, gpu_ack_o, cpu_ack_o}, {w == W_REFR, w == W_GPU, w == W_CPU});
      end
      checks++;
      if ({refr_dout_rdy_nxt_o, gpu_dout_rdy_nxt_o, cpu_dout_rdy_nxt_o} !==
          {w == W_REFR, w == W_GPU && gpu_wen_i == 2'b11, w == W_CPU && cpu_wen_i == 2'b11}) begin
        errors++; $display("FAIL rand_rdy[%0d]: got r/g/c %b required %b", cyc,
                           {refr_dout_rdy_nxt_o, gpu_dout_rdy_nxt_o, cpu_dout_rdy_nxt_o},
                           {w == W_REFR, w == W_GPU && gpu_wen_i == 2'b11, w == W_CPU && cpu_wen_i == 2'b11});
      end
      checks++;
      if (vid_ram_cen_o !== (w == W_NONE) || vid_ram_wen_o !== exp_wen(w)) begin
        errors++; $display("FAIL rand_ctl[%0d]: got cen %b wen %b required %b %b", cyc,
                           vid_ram_cen_o, vid_ram_wen_o, w == W_NONE, exp_wen(w));
      end
      checks++;
      if (vid_ram_addr_o !== exp_addr(w) || vid_ram_din_o !== exp_din(w)) begin
        errors++; $display("FAIL rand_bus[%0d]: got addr %0h din %0h required %0h %0h", cyc,
                           vid_ram_addr_o, vid_ram_din_o, exp_addr(w), exp_din(w));
      end
      if (rd_pending) begin
        checks++;
        if (vid_ram_dout_o !== rd_data) begin
          errors++; $display("FAIL rand_rdata[%0d]: got %0h required %0h", cyc, vid_ram_dout_o, rd_data);
        end
      end
      step();
      if (last_win == W_CPU)  cpu_cen_i  = 1'b1;
      if (last_win == W_GPU)  gpu_cen_i  = 1'b1;
      if (last_win == W_REFR) refr_cen_i = 1'b1;
    end
    idle_all();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    refr_turn = 1'b1;
    refr_denied = 0;
    last_addr = '0;
    last_din = '0;
    rd_pending = 1'b0;
    rd_data = '0;
    last_win = W_NONE;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    puc_rst_n = 1'b0;
    refr_addr_i = '0; gpu_addr_i = '0; cpu_addr_i = '0;
    gpu_din_i = '0; cpu_din_i = '0;
    idle_all();

    test_reset();
    test_refresh_only();
    test_round_robin();
    test_gpu_write();
    test_cpu_refresh();
    test_all_three();
    test_reset_mid_traffic();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
